// File: rtl/conv_row_pe_stream.sv
// Streaming row-convolution PE: accumulates CIN*KSIZE kernel-row beats, emits one requantised row.
// Optional build macro CONV_PE_RELU_EN clamps negative output lanes to zero after saturation.
module conv_row_pe_stream #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned ROW_LEN = 32,
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned CIN     = 3,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT   = 0,
  localparam int unsigned OUT_N  = ROW_LEN - KSIZE + 1,
  localparam int unsigned NW     = CIN * KSIZE * KSIZE,
  localparam int unsigned AW     = $clog2(NW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     w_wr_en,
  input  logic [AW-1:0]            w_addr,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROW_LEN*WIDTH-1:0] in_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_N*WIDTH-1:0]   out_row,
  output logic                     out_sat
);

  localparam int unsigned NB = CIN * KSIZE;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (WIDTH - 1));

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [BW-1:0]           beat_cnt_q;
  logic                    beat_fire_c, last_fire_c;
  logic signed [WIDTH-1:0] w_mem [NW];
  logic signed [ACC_W-1:0] acc_q [OUT_N];
  logic signed [ACC_W-1:0] sum_c [OUT_N];
  logic signed [ACC_W-1:0] shr_c [OUT_N];
  logic signed [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]        lane_c;
  logic [OUT_N*WIDTH-1:0]  row_c;
  logic                    sat_c;

  // Weight RAM: not reset, writable in any state, reads see the pre-edge value.
  always_ff @(posedge clk) begin
    if (w_wr_en && (int'(w_addr) < int'(NW))) begin
      w_mem[w_addr] <= $signed(w_data);
    end
  end

  // Per-lane MAC for the current beat, then floor shift and saturation.
  always_comb begin
    sum_c  = '{default: '0};
    shr_c  = '{default: '0};
    prod_c = '0;
    lane_c = '0;
    row_c  = '0;
    sat_c  = 1'b0;
    for (int j = 0; j < int'(OUT_N); j++) begin
      sum_c[j] = acc_q[j];
      for (int k = 0; k < int'(KSIZE); k++) begin
        prod_c = $signed(in_row[(j + k) * int'(WIDTH) +: WIDTH])
               * w_mem[AW'(int'(beat_cnt_q) * int'(KSIZE) + k)];
        sum_c[j] = sum_c[j] + ACC_W'(prod_c);
      end
      shr_c[j] = sum_c[j] >>> SHIFT;
      if (shr_c[j] > SAT_MAX) begin
        lane_c = WIDTH'(SAT_MAX);
        sat_c  = 1'b1;
      end else if (shr_c[j] < SAT_MIN) begin
        lane_c = WIDTH'(SAT_MIN);
        sat_c  = 1'b1;
      end else begin
        lane_c = shr_c[j][WIDTH-1:0];
      end
`ifdef CONV_PE_RELU_EN
      if (lane_c[WIDTH-1]) lane_c = '0;
`else
`endif
      row_c[j * int'(WIDTH) +: WIDTH] = lane_c;
    end
  end

  // Next-state: flush overrides both the input beat and the output handshake.
  always_comb begin
    state_d     = state_q;
    beat_fire_c = 1'b0;
    last_fire_c = 1'b0;
    if (flush) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            beat_fire_c = 1'b1;
            if (beat_cnt_q == BW'(NB - 1)) begin
              last_fire_c = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      beat_cnt_q <= '0;
      out_row    <= '0;
      out_sat    <= 1'b0;
      for (int j = 0; j < int'(OUT_N); j++) acc_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_ACC);
      out_valid <= (state_d == ST_HOLD);
      if (flush) begin
        beat_cnt_q <= '0;
        out_sat    <= 1'b0;
        for (int j = 0; j < int'(OUT_N); j++) acc_q[j] <= '0;
      end else if (beat_fire_c) begin
        if (last_fire_c) begin
          beat_cnt_q <= '0;
          out_row    <= row_c;
          out_sat    <= sat_c;
          for (int j = 0; j < int'(OUT_N); j++) acc_q[j] <= '0;
        end else begin
          beat_cnt_q <= beat_cnt_q + BW'(1);
          for (int j = 0; j < int'(OUT_N); j++) acc_q[j] <= sum_c[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_row_pe_stream.sv
// Randomised self-checking bench for conv_row_pe_stream against a direct convolution model.
module tb_conv_row_pe_stream;
  localparam int WIDTH   = 9;
  localparam int ROW_LEN = 32;
  localparam int KSIZE   = 3;
  localparam int CIN     = 3;
  localparam int ACC_W   = 24;
  localparam int SHIFT   = 0;
  localparam int OUT_N   = ROW_LEN - KSIZE + 1;
  localparam int NW      = CIN * KSIZE * KSIZE;
  localparam int NB      = CIN * KSIZE;
  localparam int AW      = $clog2(NW);

  logic clk = 1'b0;
  logic rst_n, flush, w_wr_en, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [AW-1:0] w_addr;
  logic [WIDTH-1:0] w_data;
  logic [ROW_LEN*WIDTH-1:0] in_row;
  logic [OUT_N*WIDTH-1:0] out_row;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [WIDTH-1:0] pix_m [NB][ROW_LEN];
  logic signed [WIDTH-1:0] w_m [NW];

  always #5 clk = ~clk;

  conv_row_pe_stream #(
    .WIDTH(WIDTH), .ROW_LEN(ROW_LEN), .KSIZE(KSIZE), .CIN(CIN), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w_wr_en(w_wr_en), .w_addr(w_addr),
    .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_sat(out_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Direct sum over channels, kernel rows and taps, then floor shift and clamp.
  task automatic model_row(output logic [OUT_N*WIDTH-1:0] row, output logic sat);
    longint s;
    longint hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    longint lo = -(longint'(1) <<< (WIDTH - 1));
    row = '0;
    sat = 1'b0;
    for (int j = 0; j < OUT_N; j++) begin
      s = 0;
      for (int c = 0; c < CIN; c++)
        for (int r = 0; r < KSIZE; r++)
          for (int k = 0; k < KSIZE; k++)
            s += longint'(pix_m[c*KSIZE+r][j+k]) * longint'(w_m[(c*KSIZE+r)*KSIZE+k]);
      s = s >>> SHIFT;
      if (s > hi) begin s = hi; sat = 1'b1; end
      else if (s < lo) begin s = lo; sat = 1'b1; end
`ifdef CONV_PE_RELU_EN
      if (s < 0) s = 0;
`else
`endif
      row[j*WIDTH +: WIDTH] = s[WIDTH-1:0];
    end
  endtask

  task automatic write_w(input int addr, input logic [WIDTH-1:0] data);
    w_wr_en = 1'b1;
    w_addr  = AW'(addr);
    w_data  = data;
    tick();
    w_wr_en = 1'b0;
    if (addr < NW) w_m[addr] = $signed(data);
  endtask

  task automatic set_all_w(input logic [WIDTH-1:0] v);
    for (int i = 0; i < NW; i++) write_w(i, v);
  endtask

  task automatic fill_all(input logic [WIDTH-1:0] v);
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < ROW_LEN; p++) pix_m[b][p] = $signed(v);
  endtask

  task automatic drive_row(input int b);
    for (int p = 0; p < ROW_LEN; p++) in_row[p*WIDTH +: WIDTH] = pix_m[b][p];
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_in_ready: in_ready=%b required 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic send_beat(input int b);
    wait_ready();
    in_valid = 1'b1;
    drive_row(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_row();
    for (int b = 0; b < NB; b++) send_beat(b);
  endtask

  task automatic recv_check(input string name, input int stall, input bit check_hold);
    logic [OUT_N*WIDTH-1:0] exp_row;
    logic exp_sat;
    int n = 0;
    model_row(exp_row, exp_sat);
    while (out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL %s_valid: out_valid=%b required 1", name, out_valid);
    end
    n_cmp++;
    if (out_row !== exp_row) begin
      n_bad++; $display("FAIL %s_row: got %h required %h", name, out_row, exp_row);
    end
    n_cmp++;
    if (out_sat !== exp_sat) begin
      n_bad++; $display("FAIL %s_sat: got %b required %b", name, out_sat, exp_sat);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      if (check_hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_row !== exp_row || out_sat !== exp_sat) begin
          n_bad++;
          $display("FAIL %s_hold: cycle %0d valid=%b ready=%b sat=%b required valid=1 ready=0 sat=%b row stable",
                   name, i, out_valid, in_ready, out_sat, exp_sat);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_release: valid=%b ready=%b required valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_row !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: valid=%b sat=%b ready=%b row=%h required 0 0 1 0", out_valid, out_sat, in_ready, out_row);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ones();
    set_all_w(9'd1);
    fill_all(9'd1);
    send_row();
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ones_latency: valid=%b ready=%b required 1 0", out_valid, in_ready);
    end
    n_cmp++;
    if (out_row[WIDTH-1:0] !== 9'd27) begin
      n_bad++; $display("FAIL ones_lane0: got %0d required 27", out_row[WIDTH-1:0]);
    end
    recv_check("ones", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_all(9'd1);
    send_row();
    recv_check("bp", 5, 1'b1);
    fill_all(9'd2);
    send_row();
    recv_check("bp_next", 0, 1'b0);
  endtask

  task automatic test_saturation();
    set_all_w(9'd255);
    fill_all(9'd255);
    send_row();
    recv_check("sat_pos", 0, 1'b0);
    fill_all(9'h100);
    send_row();
    recv_check("sat_neg", 2, 1'b1);
    fill_all(9'd255);
    send_row();
    // Flush while holding a saturated row discards it even with out_ready high.
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_hold: valid=%b sat=%b ready=%b required 0 0 1", out_valid, out_sat, in_ready);
    end
  endtask

  task automatic test_flush();
    set_all_w(9'd1);
    fill_all(9'd5);
    for (int b = 0; b < 4; b++) send_beat(b);
    wait_ready();
    flush = 1'b1;
    in_valid = 1'b1;
    drive_row(4);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_acc: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    fill_all(9'd1);
    send_row();
    recv_check("flush", 0, 1'b0);
  endtask

  task automatic test_reset_midrow();
    fill_all(9'd3);
    for (int b = 0; b < 4; b++) send_beat(b);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fill_all(9'd1);
    send_row();
    recv_check("reset_mid", 0, 1'b0);
  endtask

  task automatic test_weight_race();
    logic [OUT_N*WIDTH-1:0] exp_row;
    logic exp_sat;
    fill_all(9'd1);
    model_row(exp_row, exp_sat);
    wait_ready();
    w_wr_en  = 1'b1;
    w_addr   = '0;
    w_data   = 9'd2;
    in_valid = 1'b1;
    drive_row(0);
    tick();
    w_wr_en  = 1'b0;
    in_valid = 1'b0;
    for (int b = 1; b < NB; b++) send_beat(b);
    n_cmp++;
    if (out_row !== exp_row || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL race_old: got %h valid=%b required %h valid=1", out_row, out_valid, exp_row);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    w_m[0] = 9'sd2;
    send_row();
    recv_check("race_new", 0, 1'b0);
  endtask

  task automatic test_random();
    for (int row = 0; row < 6; row++) begin
      for (int i = 0; i < NW; i++) write_w(i, WIDTH'($urandom_range(0, 511)));
      write_w(NW + int'($urandom_range(0, (1 << AW) - NW - 1)), WIDTH'($urandom_range(0, 511)));
      for (int b = 0; b < NB; b++)
        for (int p = 0; p < ROW_LEN; p++) pix_m[b][p] = $signed(WIDTH'($urandom_range(0, 511)));
      for (int b = 0; b < NB; b++) begin
        send_beat(b);
        repeat ($urandom_range(0, 2)) tick();
      end
      recv_check("random", int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    for (int i = 0; i < NW; i++) w_m[i] = '0;
    test_reset();
    test_ones();
    test_backpressure();
    test_saturation();
    test_flush();
    test_reset_midrow();
    test_weight_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
